// File: rtl/fd_system_decode_pkg.sv
// Shared RV32I decode constants, XB bundle types and CSR op helper for the FD stage.
// FD_DECODE_ECALL_EN adds the ECALL/EBREAK/MRET encodings.
package fd_system_decode_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef FD_DECODE_ECALL_EN
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;
`endif

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_TRAP_DRAIN = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic read;
        logic write;
        logic set;
        logic clear;
        logic imm;
    } csr_ctl_t;

    typedef struct packed {
        logic pc_misaligned;
        logic unsupported;
        logic illegal;
        logic mem_misaligned;
        logic ecall;
        logic ebreak;
    } fd_exc_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [4:0]  uimm;
    } inst_fields_t;

    localparam csr_ctl_t CSR_CTL_NONE = '{default: 1'b0};
    localparam fd_exc_t  FD_EXC_NONE  = '{default: 1'b0};

    // Zicsr op controls; CSRRW/CSRRWI also read the old value.
    function automatic csr_ctl_t csr_decode(input logic [2:0] funct3);
        csr_ctl_t ctl;
        ctl = CSR_CTL_NONE;
        case (funct3[1:0])
            2'b01:   begin ctl.read = 1'b1; ctl.write = 1'b1; end
            2'b10:   begin ctl.read = 1'b1; ctl.set   = 1'b1; end
            2'b11:   begin ctl.read = 1'b1; ctl.clear = 1'b1; end
            default: ctl = CSR_CTL_NONE;
        endcase
        ctl.imm = funct3[2];
        return ctl;
    endfunction

endpackage

// File: rtl/fd_inst_classifier.sv
// Combinational FD classifier: RV32I legality, prioritised exception flags, CSR op controls.
// FD_DECODE_ECALL_EN turns ECALL/EBREAK into their own flags and MRET into a legal no-op.
module fd_inst_classifier
    import fd_system_decode_pkg::*;
(
    input  logic [31:0]  inst,
    input  logic [1:0]   pc_lsb,
    input  logic [1:0]   agu_lsb,
    output csr_ctl_t     csr_ctl,
    output fd_exc_t      exc,
    output inst_fields_t fields
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;
    logic       known_s;
    logic       legal_s;
    logic       mem_mis_s;
    logic       is_csr_s;
    logic       is_ecall_s;
    logic       is_ebreak_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign funct7_s = inst[31:25];
    assign fields   = '{rd: inst[11:7], csr: inst[31:20], uimm: inst[19:15]};

    // Opcode class, funct3/funct7 legality and access alignment.
    always_comb begin
        known_s     = 1'b1;
        legal_s     = 1'b1;
        mem_mis_s   = 1'b0;
        is_csr_s    = 1'b0;
        is_ecall_s  = 1'b0;
        is_ebreak_s = 1'b0;
        case (opcode_s)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal_s = 1'b1;
            OPC_JALR:     legal_s = (funct3_s == 3'b000);
            OPC_BRANCH:   legal_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);
            OPC_LOAD: begin
                legal_s   = funct3_s inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                mem_mis_s = ((funct3_s[1:0] == 2'b01) && agu_lsb[0]) ||
                            ((funct3_s == 3'b010) && (agu_lsb != 2'b00));
            end
            OPC_STORE: begin
                legal_s   = funct3_s inside {3'b000, 3'b001, 3'b010};
                mem_mis_s = ((funct3_s == 3'b001) && agu_lsb[0]) ||
                            ((funct3_s == 3'b010) && (agu_lsb != 2'b00));
            end
            OPC_OP_IMM: begin
                if (funct3_s == 3'b001) begin
                    legal_s = (funct7_s == F7_BASE);
                end else if (funct3_s == 3'b101) begin
                    legal_s = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_OP: legal_s = (funct7_s == F7_BASE) ||
                              ((funct7_s == F7_ALT) && ((funct3_s == 3'b000) || (funct3_s == 3'b101)));
            OPC_MISC_MEM: legal_s = (funct3_s == 3'b000) || (funct3_s == 3'b001);
            OPC_SYSTEM: begin
                if (funct3_s == 3'b000) begin
`ifdef FD_DECODE_ECALL_EN
                    is_ecall_s  = (inst == INST_ECALL);
                    is_ebreak_s = (inst == INST_EBREAK);
                    legal_s     = (inst == INST_MRET) || is_ecall_s || is_ebreak_s;
`else
                    legal_s = 1'b0;
`endif
                end else if (funct3_s == 3'b100) begin
                    legal_s = 1'b0;
                end else begin
                    is_csr_s = 1'b1;
                end
            end
            default: known_s = 1'b0;
        endcase
    end

    // Exactly one flag, highest priority first.
    always_comb begin
        exc = FD_EXC_NONE;
        if (pc_lsb != 2'b00) begin
            exc.pc_misaligned = 1'b1;
        end else if (is_ecall_s) begin
            exc.ecall = 1'b1;
        end else if (is_ebreak_s) begin
            exc.ebreak = 1'b1;
        end else if (!known_s) begin
            exc.unsupported = 1'b1;
        end else if (!legal_s) begin
            exc.illegal = 1'b1;
        end else if (mem_mis_s) begin
            exc.mem_misaligned = 1'b1;
        end else begin
            exc = FD_EXC_NONE;
        end
    end

    assign csr_ctl = (is_csr_s && (exc == FD_EXC_NONE)) ? csr_decode(funct3_s) : CSR_CTL_NONE;

endmodule

// File: rtl/fd_system_decode.sv
// FD decode plus FD->XB pipeline register with stall hold and post-trap bubble drain.
// FD_DECODE_ECALL_EN adds the XB ecall/ebreak exception outputs.
module fd_system_decode
    import fd_system_decode_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int PC_W         = 32
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            inst_valid,
    input  logic [31:0]     inst,
    input  logic [PC_W-1:0] FD_pc,
    input  logic [1:0]      agu_lsb,
    input  logic            stall,
    input  logic            initiate_illinst,
    input  logic            initiate_misaligned,
    output logic            read,
    output logic            write,
    output logic            set,
    output logic            clear,
    output logic            imm,
    output logic [4:0]      a_rd,
    output logic [11:0]     src_dst,
    output logic [4:0]      uimm,
    output logic [PC_W-1:0] XB_pc,
    output logic            XB_bubble,
    output logic            XB_FD_exception_unsupported_category,
    output logic            XB_FD_exception_illegal_instruction,
    output logic            XB_FD_exception_instruction_misaligned,
    output logic            XB_FD_exception_memory_misaligned
`ifdef FD_DECODE_ECALL_EN
    ,
    output logic            XB_FD_exception_ecall,
    output logic            XB_FD_exception_ebreak
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    csr_ctl_t     cls_ctl_s;
    fd_exc_t      cls_exc_s;
    inst_fields_t cls_fld_s;

    drain_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xb_bubble_q, xb_bubble_d;
    csr_ctl_t         ctl_q, ctl_d;
    fd_exc_t          exc_q, exc_d;
    inst_fields_t     fld_q, fld_d;
    logic [PC_W-1:0]  xb_pc_q, xb_pc_d;

    logic trap_s;
    logic xb_exc_pending_s;
    logic load_s;
    logic bubble_s;

    fd_inst_classifier u_classifier (
        .inst    (inst),
        .pc_lsb  (FD_pc[1:0]),
        .agu_lsb (agu_lsb),
        .csr_ctl (cls_ctl_s),
        .exc     (cls_exc_s),
        .fields  (cls_fld_s)
    );

    assign trap_s           = initiate_illinst | initiate_misaligned;
    assign xb_exc_pending_s = (exc_q != FD_EXC_NONE);

    // Drain FSM: a trap beats stall; younger instructions behind an untaken exception are squashed.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;
        bubble_s = 1'b1;
        if (trap_s) begin
            load_s = 1'b1;
            if (DRAIN_CYCLES > 1) begin
                state_d = ST_TRAP_DRAIN;
                cnt_d   = DRAIN_LOAD;
            end else begin
                state_d = ST_RUN;
                cnt_d   = {CNT_W{1'b0}};
            end
        end else if (stall) begin
            load_s = 1'b0;
        end else begin
            load_s = 1'b1;
            case (state_q)
                ST_RUN: bubble_s = !inst_valid || xb_exc_pending_s;
                ST_TRAP_DRAIN: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // XB next value; fields and PC follow FD even into bubbles so only the qualifiers matter.
    always_comb begin
        xb_bubble_d = xb_bubble_q;
        ctl_d       = ctl_q;
        exc_d       = exc_q;
        fld_d       = fld_q;
        xb_pc_d     = xb_pc_q;
        if (load_s) begin
            xb_bubble_d = bubble_s;
            fld_d       = cls_fld_s;
            xb_pc_d     = FD_pc;
            if (bubble_s) begin
                ctl_d = CSR_CTL_NONE;
                exc_d = FD_EXC_NONE;
            end else begin
                exc_d = cls_exc_s;
                ctl_d = (cls_exc_s != FD_EXC_NONE) ? CSR_CTL_NONE : cls_ctl_s;
            end
        end else begin
            xb_bubble_d = xb_bubble_q;
        end
    end

    // XB register and FSM state.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_RUN;
            cnt_q       <= {CNT_W{1'b0}};
            xb_bubble_q <= 1'b1;
            ctl_q       <= CSR_CTL_NONE;
            exc_q       <= FD_EXC_NONE;
            fld_q       <= '{rd: 5'd0, csr: 12'd0, uimm: 5'd0};
            xb_pc_q     <= {PC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            xb_bubble_q <= xb_bubble_d;
            ctl_q       <= ctl_d;
            exc_q       <= exc_d;
            fld_q       <= fld_d;
            xb_pc_q     <= xb_pc_d;
        end
    end

    assign read      = ctl_q.read;
    assign write     = ctl_q.write;
    assign set       = ctl_q.set;
    assign clear     = ctl_q.clear;
    assign imm       = ctl_q.imm;
    assign a_rd      = fld_q.rd;
    assign src_dst   = fld_q.csr;
    assign uimm      = fld_q.uimm;
    assign XB_pc     = xb_pc_q;
    assign XB_bubble = xb_bubble_q;
    assign XB_FD_exception_unsupported_category   = exc_q.unsupported;
    assign XB_FD_exception_illegal_instruction    = exc_q.illegal;
    assign XB_FD_exception_instruction_misaligned = exc_q.pc_misaligned;
    assign XB_FD_exception_memory_misaligned      = exc_q.mem_misaligned;
`ifdef FD_DECODE_ECALL_EN
    assign XB_FD_exception_ecall  = exc_q.ecall;
    assign XB_FD_exception_ebreak = exc_q.ebreak;
`endif

endmodule

// File: tb/tb_fd_system_decode.sv
// Directed table-driven bench for fd_system_decode plus trap/stall/reset sequences.
module tb_fd_system_decode;

    logic        clk;
    logic        resetb;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] FD_pc;
    logic [1:0]  agu_lsb;
    logic        stall;
    logic        initiate_illinst;
    logic        initiate_misaligned;
    logic        read, write, set, clear, imm;
    logic [4:0]  a_rd;
    logic [11:0] src_dst;
    logic [4:0]  uimm;
    logic [31:0] XB_pc;
    logic        XB_bubble;
    logic        exc_unsup, exc_ill, exc_pcmis, exc_memmis;
`ifdef FD_DECODE_ECALL_EN
    logic        exc_ecall, exc_ebreak;
`endif

    int n_cmp;
    int n_err;

    fd_system_decode #(.DRAIN_CYCLES(2), .PC_W(32)) dut (
        .clk                                    (clk),
        .resetb                                 (resetb),
        .inst_valid                             (inst_valid),
        .inst                                   (inst),
        .FD_pc                                  (FD_pc),
        .agu_lsb                                (agu_lsb),
        .stall                                  (stall),
        .initiate_illinst                       (initiate_illinst),
        .initiate_misaligned                    (initiate_misaligned),
        .read                                   (read),
        .write                                  (write),
        .set                                    (set),
        .clear                                  (clear),
        .imm                                    (imm),
        .a_rd                                   (a_rd),
        .src_dst                                (src_dst),
        .uimm                                   (uimm),
        .XB_pc                                  (XB_pc),
        .XB_bubble                              (XB_bubble),
        .XB_FD_exception_unsupported_category   (exc_unsup),
        .XB_FD_exception_illegal_instruction    (exc_ill),
        .XB_FD_exception_instruction_misaligned (exc_pcmis),
        .XB_FD_exception_memory_misaligned      (exc_memmis)
`ifdef FD_DECODE_ECALL_EN
        ,
        .XB_FD_exception_ecall                  (exc_ecall),
        .XB_FD_exception_ebreak                 (exc_ebreak)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {read,write,set,clear,imm}; exc = {pc_mis,unsup,illegal,mem_mis}; ec = {ecall,ebreak}
    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  agu;
        logic        bub;
        logic [4:0]  ctl;
        logic [3:0]  exc;
        logic [1:0]  ec;
        logic [4:0]  rd;
        logic [11:0] csr;
        logic [4:0]  uimm;
        logic [31:0] xpc;
    } vec_t;

    localparam logic [31:0] I_CSRRW  = 32'h3401_1173;
    localparam logic [31:0] I_CSRRSI = 32'h3004_62F3;
    localparam logic [31:0] I_LW     = 32'h0001_2083;
    localparam logic [31:0] I_LH     = 32'h0001_1083;
    localparam logic [31:0] I_CUST   = 32'h0000_000B;
    localparam logic [31:0] I_CSR100 = 32'h3401_4173;
    localparam logic [31:0] I_ADD    = 32'h0020_81B3;
    localparam logic [31:0] I_BADSLL = 32'h4020_91B3;
    localparam logic [31:0] I_ECALL  = 32'h0000_0073;
    localparam logic [31:0] I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] I_MRET   = 32'h3020_0073;

    function automatic logic [65:0] act_vec();
        logic [1:0] ec;
`ifdef FD_DECODE_ECALL_EN
        ec = {exc_ecall, exc_ebreak};
`else
        ec = 2'b00;
`endif
        return {XB_bubble, read, write, set, clear, imm,
                exc_pcmis, exc_unsup, exc_ill, exc_memmis, ec,
                a_rd, src_dst, uimm, XB_pc};
    endfunction

    function automatic logic [65:0] exp_vec(input vec_t v);
        return {v.bub, v.ctl, v.exc, v.ec, v.rd, v.csr, v.uimm, v.xpc};
    endfunction

    task automatic check(input string name, input logic [65:0] exp);
        logic [65:0] act;
        act = act_vec();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc, input logic [1:0] agu);
        inst_valid = v;
        inst       = i;
        FD_pc      = pc;
        agu_lsb    = agu;
    endtask

    vec_t tbl[25];
    vec_t e;

    initial begin
        n_cmp = 0;
        n_err = 0;
        resetb = 1'b0;
        stall = 1'b0;
        initiate_illinst = 1'b0;
        initiate_misaligned = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00);

        tbl[0]  = '{1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd0, 12'h000, 5'd0, 32'h0};
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = '{1'b1, I_CSRRW,  32'h100, 2'd0, 1'b0, 5'b11000, 4'b0000, 2'b00, 5'd2, 12'h340, 5'd2, 32'h100};
        tbl[4]  = '{1'b1, I_CSRRSI, 32'h104, 2'd0, 1'b0, 5'b10101, 4'b0000, 2'b00, 5'd5, 12'h300, 5'd8, 32'h104};
        tbl[5]  = '{1'b1, I_LW,     32'h102, 2'd0, 1'b0, 5'b00000, 4'b1000, 2'b00, 5'd1, 12'h000, 5'd2, 32'h102};
        tbl[6]  = '{1'b1, I_LW,     32'h108, 2'd0, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd1, 12'h000, 5'd2, 32'h108};
        tbl[7]  = '{1'b1, I_LW,     32'h10C, 2'd2, 1'b0, 5'b00000, 4'b0001, 2'b00, 5'd1, 12'h000, 5'd2, 32'h10C};
        tbl[8]  = '{1'b1, I_CSRRW,  32'h110, 2'd0, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd2, 12'h340, 5'd2, 32'h110};
        tbl[9]  = '{1'b1, I_LW,     32'h114, 2'd0, 1'b0, 5'b00000, 4'b0000, 2'b00, 5'd1, 12'h000, 5'd2, 32'h114};
        tbl[10] = '{1'b1, I_LH,     32'h118, 2'd1, 1'b0, 5'b00000, 4'b0001, 2'b00, 5'd1, 12'h000, 5'd2, 32'h118};
        tbl[11] = tbl[0];
`ifdef FD_DECODE_ECALL_EN
        tbl[12] = '{1'b1, I_ECALL,  32'h200, 2'd0, 1'b0, 5'b00000, 4'b0000, 2'b10, 5'd0, 12'h000, 5'd0, 32'h200};
        tbl[21] = '{1'b1, I_EBREAK, 32'h204, 2'd0, 1'b0, 5'b00000, 4'b0000, 2'b01, 5'd0, 12'h001, 5'd0, 32'h204};
        tbl[23] = '{1'b1, I_MRET,   32'h208, 2'd0, 1'b0, 5'b00000, 4'b0000, 2'b00, 5'd0, 12'h302, 5'd0, 32'h208};
`else
        tbl[12] = '{1'b1, I_ECALL,  32'h200, 2'd0, 1'b0, 5'b00000, 4'b0010, 2'b00, 5'd0, 12'h000, 5'd0, 32'h200};
        tbl[21] = '{1'b1, I_EBREAK, 32'h204, 2'd0, 1'b0, 5'b00000, 4'b0010, 2'b00, 5'd0, 12'h001, 5'd0, 32'h204};
        tbl[23] = '{1'b1, I_MRET,   32'h208, 2'd0, 1'b0, 5'b00000, 4'b0010, 2'b00, 5'd0, 12'h302, 5'd0, 32'h208};
`endif
        tbl[13] = tbl[0];
        tbl[14] = '{1'b1, I_CUST,   32'h002, 2'd0, 1'b0, 5'b00000, 4'b1000, 2'b00, 5'd0, 12'h000, 5'd0, 32'h002};
        tbl[15] = tbl[0];
        tbl[16] = '{1'b1, I_CSR100, 32'h300, 2'd0, 1'b0, 5'b00000, 4'b0010, 2'b00, 5'd2, 12'h340, 5'd2, 32'h300};
        tbl[17] = '{1'b1, I_ADD,    32'h304, 2'd0, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd3, 12'h002, 5'd1, 32'h304};
        tbl[18] = '{1'b1, I_ADD,    32'h308, 2'd0, 1'b0, 5'b00000, 4'b0000, 2'b00, 5'd3, 12'h002, 5'd1, 32'h308};
        tbl[19] = '{1'b1, I_BADSLL, 32'h30C, 2'd0, 1'b0, 5'b00000, 4'b0010, 2'b00, 5'd3, 12'h402, 5'd1, 32'h30C};
        tbl[20] = tbl[0];
        tbl[22] = tbl[0];
        tbl[24] = tbl[0];

        repeat (2) @(posedge clk);
        #1;
        e = tbl[0];
        check("reset_state", exp_vec(e));
        @(negedge clk);
        resetb = 1'b1;
        #1;

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].valid, tbl[i].inst, tbl[i].pc, tbl[i].agu);
            step();
            check($sformatf("vec%0d", i), exp_vec(tbl[i]));
        end

        // Unsupported opcode followed by a trap: exactly two bubbles, then flow resumes.
        drive(1'b1, I_CUST, 32'h104, 2'd0);
        step();
        e = '{1'b1, I_CUST, 32'h104, 2'd0, 1'b0, 5'b00000, 4'b0100, 2'b00, 5'd0, 12'h000, 5'd0, 32'h104};
        check("unsup_0B", exp_vec(e));
        drive(1'b1, I_ADD, 32'h108, 2'd0);
        initiate_illinst = 1'b1;
        step();
        initiate_illinst = 1'b0;
        e = '{1'b1, I_ADD, 32'h108, 2'd0, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd3, 12'h002, 5'd1, 32'h108};
        check("trap_bubble1", exp_vec(e));
        drive(1'b1, I_ADD, 32'h10C, 2'd0);
        step();
        e.xpc = 32'h10C;
        check("trap_bubble2", exp_vec(e));
        step();
        e.bub = 1'b0;
        check("trap_resume", exp_vec(e));

        // Stall holds a CSRRSI; a trap during stall still bubbles.
        drive(1'b1, I_CSRRSI, 32'h120, 2'd0);
        step();
        e = '{1'b1, I_CSRRSI, 32'h120, 2'd0, 1'b0, 5'b10101, 4'b0000, 2'b00, 5'd5, 12'h300, 5'd8, 32'h120};
        check("csrrsi_load", exp_vec(e));
        stall = 1'b1;
        drive(1'b1, I_ADD, 32'h400, 2'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("stall_hold%0d", k), exp_vec(e));
        end
        initiate_misaligned = 1'b1;
        step();
        initiate_misaligned = 1'b0;
        stall = 1'b0;
        e = '{1'b1, I_ADD, 32'h400, 2'd0, 1'b1, 5'b00000, 4'b0000, 2'b00, 5'd3, 12'h002, 5'd1, 32'h400};
        check("stall_trap_bubble", exp_vec(e));
        drive(1'b1, I_ADD, 32'h404, 2'd0);
        step();
        e.xpc = 32'h404;
        check("stall_trap_drain", exp_vec(e));
        step();
        e.bub = 1'b0;
        check("stall_trap_resume", exp_vec(e));

        // Async reset mid-drain returns to RUN.
        drive(1'b1, I_ADD, 32'h500, 2'd0);
        initiate_illinst = 1'b1;
        step();
        initiate_illinst = 1'b0;
        #2;
        resetb = 1'b0;
        #1;
        e = tbl[0];
        check("async_reset_mid_drain", exp_vec(e));
        #3;
        resetb = 1'b1;
        step();
        e = '{1'b1, I_ADD, 32'h500, 2'd0, 1'b0, 5'b00000, 4'b0000, 2'b00, 5'd3, 12'h002, 5'd1, 32'h500};
        check("after_reset_run", exp_vec(e));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
